// File: rtl/serial_frame_deser.sv
// ----------------------------------------------------------------------------
// serial_frame_deser
//
// Purpose:
//   Assembles a strobed serial bit stream into parallel words. A frame is a
//   start bit (1), WIDTH data bits sent MSB first, and a stop bit (0). The
//   line idles at 0. Good words are offered on a valid/ready handshake.
//   A bad stop bit raises a one-cycle frame_err pulse. A good frame that
//   arrives while the previous word is still unconsumed is dropped, and a
//   one-cycle overrun pulse is raised instead.
//
// Ports:
//   clk        in   rising-edge clock, shared with the upstream sampling flop
//   clear      in   asynchronous active-low reset
//   bit_en     in   bit strobe; din is only looked at when this is 1
//   din        in   serial data, already synchronous to clk
//   data_out   out  WIDTH  last good word, MSB = first data bit received
//   data_valid out  data_out holds a word that has not been consumed yet
//   data_ready in   consumer takes the word on an edge where data_valid=1
//   frame_err  out  one-cycle pulse after a stop bit sampled as 1
//   overrun    out  one-cycle pulse after a good frame was dropped
//   busy       out  high while a frame is in progress (SHIFT or STOP)
// ----------------------------------------------------------------------------
module serial_frame_deser #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             bit_en,
   input  logic             din,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      STOP  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [CNT_W-1:0] r_bitCnt;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] r_dataOut;
   logic             r_dataValid;
   logic             r_frameErr;
   logic             r_overrun;

   logic             w_busy;
   logic             w_stopStrobe;
   logic             w_goodStop;
   logic             w_canLoad;
   logic             w_load;
   logic             w_overrunEvt;
   logic             w_frameErrEvt;
   logic             w_accept;

   // State register. Clearing mid-frame drops straight back to IDLE, which
   // throws away whatever has been shifted so far; no partial word escapes
   // because only the STOP strobe ever loads data_out.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. Nothing moves without a strobe, so any number of
   // non-strobed cycles between bits simply freezes the frame in place.
   // STOP always returns to IDLE, so a start bit on the very next strobe
   // is picked up without any mandatory idle bit.
   always_comb begin
      w_nextState = r_state;
      if (bit_en) begin
         case (r_state)
            IDLE: begin
               if (din) begin
                  w_nextState = SHIFT;
               end
            end
            SHIFT: begin
               if (r_bitCnt == LAST_BIT) begin
                  w_nextState = STOP;
               end
            end
            STOP: begin
               w_nextState = IDLE;
            end
            default: begin
               w_nextState = IDLE;
            end
         endcase
      end
   end

   // Output decode. The stop strobe resolves into exactly one of three
   // outcomes: load, overrun or framing error. A consumer accepting on the
   // same edge as a good stop bit frees the slot, so that case loads the
   // new word rather than counting as an overrun.
   always_comb begin
      w_busy        = (r_state == SHIFT) || (r_state == STOP);
      w_stopStrobe  = bit_en && (r_state == STOP);
      w_goodStop    = w_stopStrobe && !din;
      w_canLoad     = !r_dataValid || data_ready;
      w_load        = w_goodStop && w_canLoad;
      w_overrunEvt  = w_goodStop && !w_canLoad;
      w_frameErrEvt = w_stopStrobe && din;
      w_accept      = r_dataValid && data_ready;
   end

   // Bit counter and shift register. The counter is zeroed when the start
   // bit is seen, and the shift register needs no clearing at that point
   // since every one of its WIDTH bits is overwritten before STOP.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_bitCnt <= '0;
         r_shreg  <= '0;
      end else if (bit_en) begin
         case (r_state)
            IDLE: begin
               if (din) begin
                  r_bitCnt <= '0;
               end
            end
            SHIFT: begin
               r_shreg  <= {r_shreg[WIDTH-2:0], din};
               r_bitCnt <= r_bitCnt + CNT_W'(1);
            end
            default: begin
               r_bitCnt <= r_bitCnt;
            end
         endcase
      end
   end

   // Output word and handshake. A load takes priority over an accept, so
   // that valid stays high when a word is consumed and replaced on the same
   // edge. The pulses are rewritten every cycle, so they last one clock.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         r_dataOut   <= '0;
         r_dataValid <= 1'b0;
         r_frameErr  <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frameErr <= w_frameErrEvt;
         r_overrun  <= w_overrunEvt;
         if (w_load) begin
            r_dataOut   <= r_shreg;
            r_dataValid <= 1'b1;
         end else if (w_accept) begin
            r_dataValid <= 1'b0;
         end
      end
   end

   assign data_out   = r_dataOut;
   assign data_valid = r_dataValid;
   assign frame_err  = r_frameErr;
   assign overrun    = r_overrun;
   assign busy       = w_busy;

endmodule

// File: tb/tb_serial_frame_deser.sv
// ----------------------------------------------------------------------------
// tb_serial_frame_deser
//
// Directed frames go in through the stimulus process, which pushes the
// hand-worked outcome of each frame (load / overrun / framing error, plus the
// word and valid flag expected alongside it) into a queue. An independent
// monitor watches the outputs on the falling edge, recognises each frame
// outcome as it appears, and pops the queue to compare.
// ----------------------------------------------------------------------------
module tb_serial_frame_deser;

   localparam int WIDTH = 8;
   localparam int KLOAD = 0;
   localparam int KOVR  = 1;
   localparam int KFERR = 2;

   typedef struct {
      int               kind;
      logic [WIDTH-1:0] data;
      logic             valid;
   } exp_t;

   logic             clk = 1'b0;
   logic             clear;
   logic             bitEn;
   logic             din;
   logic             dataReady;
   logic [WIDTH-1:0] dataOut;
   logic             dataValid;
   logic             frameErr;
   logic             overrun;
   logic             busy;

   int   compared   = 0;
   int   mismatched = 0;
   exp_t expQ[$];

   logic             prevValid = 1'b0;
   logic             prevReady = 1'b0;
   logic [WIDTH-1:0] prevData  = '0;

   serial_frame_deser #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .clear      (clear),
      .bit_en     (bitEn),
      .din        (din),
      .data_out   (dataOut),
      .data_valid (dataValid),
      .data_ready (dataReady),
      .frame_err  (frameErr),
      .overrun    (overrun),
      .busy       (busy)
   );

   // 20 ns clock period
   always #10 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] got,
                              input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   // Called at posedge+2 with bitEn low; idles for gap cycles, then strobes
   // one bit. Returns at posedge+2 after the sampling edge.
   task automatic strobeBit(input logic b, input int gap, input logic rdy);
      repeat (gap) begin
         @(posedge clk);
         #2;
      end
      din       = b;
      bitEn     = 1'b1;
      dataReady = rdy;
      @(posedge clk);
      #2;
      bitEn     = 1'b0;
      dataReady = 1'b0;
   endtask

   // Sends one whole frame and records the outcome the monitor should see.
   task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic stopBit,
                                input int gap, input bit randGap,
                                input logic rdyOnStop, input int kind,
                                input logic [WIDTH-1:0] expData,
                                input logic expValid);
      exp_t e;
      int   g;
      e.kind  = kind;
      e.data  = expData;
      e.valid = expValid;
      expQ.push_back(e);
      g = randGap ? int'($urandom_range(7, 1)) : gap;
      strobeBit(1'b1, g, 1'b0);
      checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         g = randGap ? int'($urandom_range(7, 1)) : gap;
         strobeBit(data[i], g, 1'b0);
      end
      checkOutput("busy_in_stop", {31'd0, busy}, 32'd1);
      g = randGap ? int'($urandom_range(7, 1)) : gap;
      strobeBit(stopBit, g, rdyOnStop);
      checkOutput("busy_after_stop", {31'd0, busy}, 32'd0);
   endtask

   // One-cycle data_ready pulse that should empty the output slot.
   task automatic consumeWord();
      @(posedge clk);
      #2;
      dataReady = 1'b1;
      @(posedge clk);
      #2;
      dataReady = 1'b0;
      checkOutput("valid_after_accept", {31'd0, dataValid}, 32'd0);
   endtask

   // Monitor: classifies each falling-edge view of the outputs into a frame
   // outcome and checks it against the oldest queued expectation. It also
   // checks that a pending, unaccepted word never changes.
   always @(negedge clk) begin
      if (!clear) begin
         prevValid = 1'b0;
         prevReady = 1'b0;
         prevData  = '0;
      end else begin
         int   kind;
         bit   evt;
         exp_t e;
         evt  = 1'b0;
         kind = KLOAD;
         if (frameErr && overrun) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL pulses_together: frame_err=1 overrun=1 required not both");
         end
         if (overrun) begin
            evt  = 1'b1;
            kind = KOVR;
         end else if (frameErr) begin
            evt  = 1'b1;
            kind = KFERR;
         end else if (dataValid && (!prevValid || prevReady)) begin
            evt  = 1'b1;
            kind = KLOAD;
         end
         if (prevValid && !prevReady) begin
            checkOutput("held_valid", {31'd0, dataValid}, 32'd1);
            checkOutput("held_data", {24'd0, dataOut}, {24'd0, prevData});
         end
         if (evt) begin
            if (expQ.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_event: got kind %0d with data %0h, expected no event",
                        kind, dataOut);
            end else begin
               e = expQ.pop_front();
               checkOutput("event_kind", kind, e.kind);
               checkOutput("event_data", {24'd0, dataOut}, {24'd0, e.data});
               checkOutput("event_valid", {31'd0, dataValid}, {31'd0, e.valid});
            end
         end
         prevValid = dataValid;
         prevReady = dataReady;
         prevData  = dataOut;
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #1ms;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clear     = 1'b0;
      bitEn     = 1'b0;
      din       = 1'b0;
      dataReady = 1'b0;

      // Reset values while clear is low
      #30;
      checkOutput("rst_data", {24'd0, dataOut}, 32'd0);
      checkOutput("rst_valid", {31'd0, dataValid}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_ferr", {31'd0, frameErr}, 32'd0);
      checkOutput("rst_ovr", {31'd0, overrun}, 32'd0);
      #10;
      clear = 1'b1;
      @(posedge clk);
      #2;

      // Single frame 0xA5, strobe every 5th cycle, nobody consuming
      $display("[TB] single frame 0xA5");
      applyStimulus(8'hA5, 1'b0, 4, 1'b0, 1'b0, KLOAD, 8'hA5, 1'b1);
      checkOutput("first_data", {24'd0, dataOut}, 32'hA5);

      // Accept, then back-to-back frame 0x3C
      $display("[TB] handshake then 0x3C");
      consumeWord();
      applyStimulus(8'h3C, 1'b0, 4, 1'b0, 1'b0, KLOAD, 8'h3C, 1'b1);
      consumeWord();

      // Ready held on the loading edge: 0xA5 replaced by 0x3C in one edge
      $display("[TB] accept and load on same edge");
      applyStimulus(8'hA5, 1'b0, 0, 1'b0, 1'b0, KLOAD, 8'hA5, 1'b1);
      applyStimulus(8'h3C, 1'b0, 0, 1'b0, 1'b1, KLOAD, 8'h3C, 1'b1);
      checkOutput("swap_valid", {31'd0, dataValid}, 32'd1);
      checkOutput("swap_data", {24'd0, dataOut}, 32'h3C);
      checkOutput("swap_no_ovr", {31'd0, overrun}, 32'd0);
      consumeWord();

      // Overrun: 0xA5 left pending, 0xFF dropped
      $display("[TB] overrun");
      applyStimulus(8'hA5, 1'b0, 4, 1'b0, 1'b0, KLOAD, 8'hA5, 1'b1);
      applyStimulus(8'hFF, 1'b0, 4, 1'b0, 1'b0, KOVR, 8'hA5, 1'b1);
      @(posedge clk);
      #2;
      checkOutput("ovr_pulse_gone", {31'd0, overrun}, 32'd0);
      consumeWord();

      // Framing error on 0x81, then good 0x42
      $display("[TB] framing error");
      applyStimulus(8'h81, 1'b1, 4, 1'b0, 1'b0, KFERR, 8'hA5, 1'b0);
      applyStimulus(8'h42, 1'b0, 4, 1'b0, 1'b0, KLOAD, 8'h42, 1'b1);

      // Asynchronous clear after four data bits of an aborted frame
      $display("[TB] reset mid-frame");
      strobeBit(1'b1, 4, 1'b0);
      strobeBit(1'b0, 4, 1'b0);
      strobeBit(1'b1, 4, 1'b0);
      strobeBit(1'b0, 4, 1'b0);
      strobeBit(1'b1, 4, 1'b0);
      #5;
      clear = 1'b0;
      #1;
      checkOutput("midrst_data", {24'd0, dataOut}, 32'd0);
      checkOutput("midrst_valid", {31'd0, dataValid}, 32'd0);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #2;
      clear = 1'b1;
      applyStimulus(8'h5A, 1'b0, 4, 1'b0, 1'b0, KLOAD, 8'h5A, 1'b1);
      consumeWord();

      // Line high without strobes must not start a frame
      $display("[TB] idle line and strobe gaps");
      din = 1'b1;
      repeat (50) @(posedge clk);
      #2;
      checkOutput("idle_busy", {31'd0, busy}, 32'd0);
      checkOutput("idle_valid", {31'd0, dataValid}, 32'd0);
      din = 1'b0;
      applyStimulus(8'hC3, 1'b0, 0, 1'b1, 1'b0, KLOAD, 8'hC3, 1'b1);
      checkOutput("gap_data", {24'd0, dataOut}, 32'hC3);
      consumeWord();

      repeat (10) @(posedge clk);
      #2;
      checkOutput("queue_empty", expQ.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_frame_deser.md
Name: serial_frame_deser

Overview:
- Downstream stage of the D flip-flop sampling stage; consumes its registered serial bit stream (q) and assembles fixed-length frames into parallel words.
- Detects a start bit, shifts in WIDTH data bits MSB-first, and checks a stop bit.
- Delivers each good word over a valid/ready handshake, and flags framing errors and overruns.
- All logic runs in the flip-flop's clock domain; bit timing comes from an external qualifying strobe.

Parameters:
- WIDTH, 8, number of data bits per frame (legal range 2..32).

Ports:
- clk  input  1  rising-edge system clock (same clock as the sampling flip-flop).
- clear  input  1  asynchronous, active-low reset; all state returns to reset values immediately while clear=0.
- bit_en  input  1  bit strobe; din is sampled only on rising edges where bit_en=1.
- din  input  1  serial data (q of the upstream flip-flop).
- data_out  output  WIDTH  last good frame word, MSB = first data bit received.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts the word on an edge where data_valid=1.
- frame_err  output  1  one-cycle pulse: stop bit was 1.
- overrun  output  1  one-cycle pulse: good frame dropped because the previous word was unconsumed.
- busy  output  1  high while in SHIFT or STOP.

Behaviour:
- Reset (clear=0):
  - state=IDLE, bit counter=0, shift register=0.
  - data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0.
  - Asserting clear mid-frame aborts the frame; no partial word is ever output.
- States: IDLE, SHIFT, STOP. Transitions happen only on edges with bit_en=1, except reset.
- IDLE:
  - bit_en=1 and din=1 (start bit) -> SHIFT, counter=0.
  - din=0 stays in IDLE (line idle level is 0).
- SHIFT:
  - Each strobed edge: shreg <= {shreg[WIDTH-2:0], din}, counter++.
  - On the strobe that captures bit WIDTH-1 (counter = WIDTH-1) -> STOP.
- STOP, on a strobed edge:
  - din=0, with data_valid=0 or data_ready=1: data_out<=shreg, data_valid<=1.
  - din=0, with data_valid=1 and data_ready=0: old word kept; overrun=1 for exactly one clk; new word discarded.
  - din=1: frame_err=1 for exactly one clk; data_out/data_valid untouched apart from the normal handshake.
  - Every case -> IDLE.
- Latency: data_valid rises on the clk edge sampling the stop bit, i.e. the (WIDTH+2)th strobe counting the start bit as the first.
- Handshake:
  - data_valid clears on any edge with data_valid=1 and data_ready=1, unless a good stop bit loads a new word on that same edge. In that case valid stays 1, data_out takes the new word, and overrun does not fire.
  - data_out is stable while data_valid=1 and not accepted.
  - data_ready while data_valid=0 is ignored.
- Strobe gaps: bit_en=0 cycles freeze state, counter and shreg; any number of idle cycles between strobes is legal.
- A start bit may be sampled on the strobe immediately after the stop strobe; there are no mandatory idle bits.
- busy=1 exactly when state is SHIFT or STOP.
- frame_err and overrun are never asserted together and are 0 in every cycle except the one after the stop-bit edge.
- din is assumed already synchronous (it comes from the upstream flop); no internal synchronizer.

Test Plan:
- Reset then single frame (WIDTH=8, clk period 20 ns, bit_en every 5th cycle, data_ready=0):
  - Stimulus: clear=0 for 40 ns, then 1; strobed bits 1, 1,0,1,0,0,1,0,1, 0.
  - Required: data_out=8'hA5 and data_valid=1 on the 10th strobe edge; busy high strobes 2-10; frame_err=overrun=0.
- Handshake and back-to-back frames:
  - Stimulus: raise data_ready for one cycle after the first frame; send 0x3C immediately (start on the strobe after stop).
  - Required: data_valid drops for the gap, then data_out=8'h3C, data_valid=1.
  - Repeat with data_ready=1 held on the loading edge -> valid stays 1 and data_out switches 0xA5 -> 0x3C in one edge, no overrun.
- Overrun:
  - Stimulus: leave 0xA5 unconsumed with data_ready=0; send frame 0xFF.
  - Required: one-cycle overrun pulse; data_out stays 8'hA5; data_valid stays 1.
- Framing error:
  - Stimulus: frame 0x81 with stop bit 1.
  - Required: one-cycle frame_err pulse; data_valid unchanged (0 if previously empty); FSM returns to IDLE; next good frame 0x42 is received correctly.
- Reset mid-frame:
  - Stimulus: assert clear=0 asynchronously (not clk-aligned) after 4 data bits; release; send 0x5A.
  - Required: outputs go to 0 immediately during clear; busy=0; no word from the aborted frame; 0x5A received intact.
- Idle line and strobe gaps:
  - Stimulus: din=1 with bit_en=0 for 50 cycles -> remains IDLE, busy=0.
  - Stimulus: bit_en pattern with random 1-7 cycle gaps carrying frame 0xC3.
  - Required: data_out=8'hC3.
